// File: rtl/pcie_tl_pkg.sv
// Shared types and constants for the PCIe transaction-layer VC0 drain path.
package pcie_tl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } rd_state_e;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int SKID_DEPTH     = 2;

endpackage

// File: rtl/vc0_skid_buf.sv
// Two-entry FIFO-ordered skid buffer: entry 0 is always the head.
module vc0_skid_buf
    import pcie_tl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ,
    output logic                  overflow
);

    localparam logic [1:0] FULL_OCC = 2'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic                  pop_eff;
    logic                  full;

    assign pop_eff  = pop && (occ != 2'd0);
    assign full     = (occ == FULL_OCC);
    // A landing word with nowhere to go is dropped and flagged.
    assign overflow = push && full && !pop_eff;
    assign head     = entry0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        entry0 <= push_data;
                    end else if (occ == 2'd1) begin
                        entry1 <= push_data;
                    end
                    if (!full) begin
                        occ <= occ + 2'd1;
                    end
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/vc0_fifo_reader.sv
// VC0 transmit FIFO drain controller: read strobes, latency absorption, valid/ready output.
// Optional delivered-word counter enabled by defining VC0_READER_STATS_EN.
module vc0_fifo_reader
    import pcie_tl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  fifo_empty,
    input  logic                  fifo_error,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            state,
    output logic                  err,
    output logic [7:0]            rd_count
);

    rd_state_e  cur_state;
    rd_state_e  nxt_state;
    logic       inflight;
    logic [1:0] occ;
    logic       pop;
    logic       overflow;
    logic [2:0] projected;

    vc0_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data(fifo_data),
        .pop      (pop),
        .head     (out_data),
        .occ      (occ),
        .overflow (overflow)
    );

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign state     = cur_state;
    assign err       = (cur_state == ST_ERROR);

    // Occupancy after this cycle's landing word and pop, before this strobe's word lands.
    assign projected  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = (cur_state == ST_RUN) && !fifo_empty && !pause && (projected < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            inflight  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            inflight  <= fifo_rd_en;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (enable) nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (pause || !enable) nxt_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pause && enable) begin
                    nxt_state = ST_RUN;
                end else if (!enable && (occ == 2'd0) && !inflight) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_ERROR;
        endcase
        if (fifo_error || overflow) nxt_state = ST_ERROR;
    end

`ifdef VC0_READER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= 8'd0;
        end else if (pop) begin
            rd_count <= rd_count + 8'd1;
        end
    end
`else
    assign rd_count = 8'd0;
`endif

endmodule

// File: tb/tb_vc0_fifo_reader.sv
// Directed bench for vc0_fifo_reader with a registered-read FIFO model.
module tb_vc0_fifo_reader;

    localparam int DW = 6;
`ifdef VC0_READER_STATS_EN
    localparam logic [7:0] EXP_CNT_257 = 8'd1;
`else
    localparam logic [7:0] EXP_CNT_257 = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          pause = 1'b0;
    logic          fifo_empty;
    logic          fifo_error = 1'b0;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    state;
    logic          err;
    logic [7:0]    rd_count;

    logic [DW-1:0] mem [0:511];
    logic [8:0]    wr_ptr = 9'd0;
    logic [8:0]    rd_ptr;
    int            underflow = 0;
    int            rd_seen = 0;
    logic [DW-1:0] got [$];

    int total = 0;
    int fails = 0;

    vc0_fifo_reader #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pause     (pause),
        .fifo_empty(fifo_empty),
        .fifo_error(fifo_error),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (state),
        .err       (err),
        .rd_count  (rd_count)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, zero when not reading.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= 9'd0;
            fifo_data <= '0;
        end else if (fifo_rd_en) begin
            if (fifo_empty) underflow = underflow + 1;
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 9'd1;
        end else begin
            fifo_data <= '0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (fifo_rd_en) rd_seen = rd_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        pause      = 1'b0;
        out_ready  = 1'b0;
        fifo_error = 1'b0;
        wr_ptr     = 9'd0;
        step(2);
        got.delete();
        rd_seen = 0;
        reset   = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + DW'(i);
            wr_ptr = wr_ptr + 9'd1;
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);

        // Burst of 3 with ready high
        load(6'h01, 3);
        enable = 1'b1;
        out_ready = 1'b1;
        check("b1_idle_rd", 32'(fifo_rd_en), 32'd0);
        step();
        check("b1_state_run", 32'(state), 32'd1);
        check("b1_rd_c1", 32'(fifo_rd_en), 32'd1);
        step();
        check("b1_rd_c2", 32'(fifo_rd_en), 32'd1);
        check("b1_valid_c2", 32'(out_valid), 32'd0);
        step();
        check("b1_rd_c3", 32'(fifo_rd_en), 32'd1);
        check("b1_valid_c3", 32'(out_valid), 32'd1);
        check("b1_data_c3", 32'(out_data), 32'h01);
        step();
        check("b1_rd_c4", 32'(fifo_rd_en), 32'd0);
        check("b1_data_c4", 32'(out_data), 32'h02);
        step();
        check("b1_data_c5", 32'(out_data), 32'h03);
        step();
        check("b1_valid_c6", 32'(out_valid), 32'd0);
        check("b1_reads", 32'(rd_seen), 32'd3);

        // Burst of 3 with ready low: buffer fills at two words
        do_reset();
        load(6'h01, 3);
        enable = 1'b1;
        step(4);
        check("b2_occ", 32'(dut.occ), 32'd2);
        check("b2_reads", 32'(rd_seen), 32'd2);
        check("b2_rd_held", 32'(fifo_rd_en), 32'd0);
        check("b2_head", 32'(out_data), 32'h01);
        step();
        check("b2_head_hold", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        step(6);
        check("b2_ngot", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("b2_got%0d", i), 32'(got[i]), 32'(i + 1));
        check("b2_reads_all", 32'(rd_seen), 32'd3);

        // Pause pulse mid-burst of 5
        do_reset();
        load(6'h10, 5);
        enable = 1'b1;
        out_ready = 1'b1;
        step(3);
        pause = 1'b1;
        step();
        check("p_drain", 32'(state), 32'd2);
        pause = 1'b0;
        step();
        check("p_run", 32'(state), 32'd1);
        step(10);
        check("p_ngot", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            check($sformatf("p_got%0d", i), 32'(got[i]), 32'(8'h10 + i));

        // FIFO error in RUN with two words buffered
        do_reset();
        load(6'h01, 3);
        enable = 1'b1;
        step(4);
        fifo_error = 1'b1;
        step();
        fifo_error = 1'b0;
        out_ready = 1'b1;
        check("e_state", 32'(state), 32'd3);
        check("e_err", 32'(err), 32'd1);
        check("e_rd_blocked", 32'(fifo_rd_en), 32'd0);
        check("e_fifo_nonempty", 32'(fifo_empty), 32'd0);
        step(3);
        check("e_ngot", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("e_got0", 32'(got[0]), 32'h01);
            check("e_got1", 32'(got[1]), 32'h02);
        end
        enable = 1'b0;
        step(2);
        check("e_sticky", 32'(state), 32'd3);
        check("e_err_sticky", 32'(err), 32'd1);
        do_reset();
        check("e_reset_idle", 32'(state), 32'd0);
        check("e_reset_err", 32'(err), 32'd0);

        // Asynchronous reset with a full buffer
        load(6'h21, 3);
        enable = 1'b1;
        step(4);
        check("a_full", 32'(dut.occ), 32'd2);
        check("a_valid_pre", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("a_valid_async", 32'(out_valid), 32'd0);
        check("a_data_async", 32'(out_data), 32'd0);
        check("a_state_async", 32'(state), 32'd0);
        do_reset();

        // 257 deliveries exercise the counter wrap
        load(6'h00, 257);
        enable = 1'b1;
        out_ready = 1'b1;
        step(270);
        check("c_ngot", 32'(got.size()), 32'd257);
        check("c_rd_count", 32'(rd_count), 32'(EXP_CNT_257));
        check("c_underflow", 32'(underflow), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
